// File: rtl/lfsr_pkg.sv
// Shared constants and the Fibonacci tap table for the LFSR PRNG.
package lfsr_pkg;

    localparam int LFSR_MIN_BITS = 3;
    localparam int LFSR_MAX_BITS = 32;

    // Mask bit for a 1-indexed tap position (tap N is the MSB of an N-bit register).
    function automatic logic [31:0] f_tap_bit(int k);
        return 32'd1 << (k - 1);
    endfunction

    // XNOR-feedback taps for a maximal-length sequence of each supported width.
    function automatic logic [31:0] f_lfsr_taps(int n);
        logic [31:0] m;
        m = '0;
        case (n)
            3:  m = f_tap_bit(3)  | f_tap_bit(2);
            4:  m = f_tap_bit(4)  | f_tap_bit(3);
            5:  m = f_tap_bit(5)  | f_tap_bit(3);
            6:  m = f_tap_bit(6)  | f_tap_bit(5);
            7:  m = f_tap_bit(7)  | f_tap_bit(6);
            8:  m = f_tap_bit(8)  | f_tap_bit(6)  | f_tap_bit(5) | f_tap_bit(4);
            9:  m = f_tap_bit(9)  | f_tap_bit(5);
            10: m = f_tap_bit(10) | f_tap_bit(7);
            11: m = f_tap_bit(11) | f_tap_bit(9);
            12: m = f_tap_bit(12) | f_tap_bit(6)  | f_tap_bit(4) | f_tap_bit(1);
            13: m = f_tap_bit(13) | f_tap_bit(4)  | f_tap_bit(3) | f_tap_bit(1);
            14: m = f_tap_bit(14) | f_tap_bit(5)  | f_tap_bit(3) | f_tap_bit(1);
            15: m = f_tap_bit(15) | f_tap_bit(14);
            16: m = f_tap_bit(16) | f_tap_bit(15) | f_tap_bit(13) | f_tap_bit(4);
            17: m = f_tap_bit(17) | f_tap_bit(14);
            18: m = f_tap_bit(18) | f_tap_bit(11);
            19: m = f_tap_bit(19) | f_tap_bit(6)  | f_tap_bit(2) | f_tap_bit(1);
            20: m = f_tap_bit(20) | f_tap_bit(17);
            21: m = f_tap_bit(21) | f_tap_bit(19);
            22: m = f_tap_bit(22) | f_tap_bit(21);
            23: m = f_tap_bit(23) | f_tap_bit(18);
            24: m = f_tap_bit(24) | f_tap_bit(23) | f_tap_bit(22) | f_tap_bit(17);
            25: m = f_tap_bit(25) | f_tap_bit(22);
            26: m = f_tap_bit(26) | f_tap_bit(6)  | f_tap_bit(2) | f_tap_bit(1);
            27: m = f_tap_bit(27) | f_tap_bit(5)  | f_tap_bit(2) | f_tap_bit(1);
            28: m = f_tap_bit(28) | f_tap_bit(25);
            29: m = f_tap_bit(29) | f_tap_bit(27);
            30: m = f_tap_bit(30) | f_tap_bit(6)  | f_tap_bit(4) | f_tap_bit(1);
            31: m = f_tap_bit(31) | f_tap_bit(28);
            32: m = f_tap_bit(32) | f_tap_bit(22) | f_tap_bit(2) | f_tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Fibonacci XNOR LFSR: one maximal-length step per enabled clock, reseedable,
// with a combinational match flag against the presented seed.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done
);

    if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
        $error("lfsr_prng: NUM_BITS=%0d outside %0d..%0d", NUM_BITS, LFSR_MIN_BITS, LFSR_MAX_BITS);
    end

    localparam logic [NUM_BITS-1:0] TAP_MASK = NUM_BITS'(f_lfsr_taps(NUM_BITS));

    logic [NUM_BITS-1:0] r_LFSR;
    logic                w_feedback;

    // XNOR feedback makes all-ones the lock-up state, so all-zero is a legal start.
    assign w_feedback = ~^(r_LFSR & TAP_MASK);

    // Reset beats seed load, seed load beats stepping; otherwise hold.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_LFSR <= '0;
        end else if (i_Seed_DV) begin
            r_LFSR <= i_Seed_Data;
        end else if (i_Enable) begin
            r_LFSR <= {r_LFSR[NUM_BITS-2:0], w_feedback};
        end
    end

    assign o_LFSR_Data = r_LFSR;
    assign o_LFSR_Done = (r_LFSR == i_Seed_Data);

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: directed scenarios plus random control,
// every cycle compared against a tap-list sequence model.
module tb_lfsr_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N=8 instance
    logic       rst8_n, en8, dv8;
    logic [7:0] seed8, data8;
    logic       done8;

    // Width-sweep instances share control
    logic        rs_n, ens, dvs;
    logic [2:0]  seed3, data3;
    logic        done3;
    logic [3:0]  seed4, data4;
    logic        done4;
    logic [15:0] seed16, data16;
    logic        done16;

    lfsr_prng #(.NUM_BITS(8)) u_dut8 (
        .i_Clk(clk), .i_Rst_L(rst8_n), .i_Enable(en8), .i_Seed_DV(dv8),
        .i_Seed_Data(seed8), .o_LFSR_Data(data8), .o_LFSR_Done(done8));

    lfsr_prng #(.NUM_BITS(3)) u_dut3 (
        .i_Clk(clk), .i_Rst_L(rs_n), .i_Enable(ens), .i_Seed_DV(dvs),
        .i_Seed_Data(seed3), .o_LFSR_Data(data3), .o_LFSR_Done(done3));

    lfsr_prng #(.NUM_BITS(4)) u_dut4 (
        .i_Clk(clk), .i_Rst_L(rs_n), .i_Enable(ens), .i_Seed_DV(dvs),
        .i_Seed_Data(seed4), .o_LFSR_Data(data4), .o_LFSR_Done(done4));

    lfsr_prng #(.NUM_BITS(16)) u_dut16 (
        .i_Clk(clk), .i_Rst_L(rs_n), .i_Enable(ens), .i_Seed_DV(dvs),
        .i_Seed_Data(seed16), .o_LFSR_Data(data16), .o_LFSR_Done(done16));

    logic [31:0] m8, m3, m4, m16;

    // Next pattern: shift left, new bit 0 = NOT(parity of the listed 1-indexed taps).
    function automatic logic [31:0] lfsr_next(int n, logic [31:0] s);
        int taps[$];
        int parity;
        logic [31:0] mask;
        parity = 0;
        case (n)
            3:  taps = '{3, 2};
            4:  taps = '{4, 3};
            8:  taps = '{8, 6, 5, 4};
            16: taps = '{16, 15, 13, 4};
            default: taps = '{};
        endcase
        foreach (taps[i]) parity = parity ^ int'(s[taps[i] - 1]);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return ((s << 1) | ((parity == 0) ? 32'd1 : 32'd0)) & mask;
    endfunction

    function automatic logic [31:0] model_apply(int n, logic [31:0] cur, logic rst_n,
                                                logic dv, logic [31:0] seed, logic en);
        if (!rst_n)  return 32'd0;
        if (dv)      return seed;
        if (en)      return lfsr_next(n, cur);
        return cur;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance all models with the inputs sampled at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        m8  = model_apply(8,  m8,  rst8_n, dv8, 32'(seed8),  en8);
        m3  = model_apply(3,  m3,  rs_n,   dvs, 32'(seed3),  ens);
        m4  = model_apply(4,  m4,  rs_n,   dvs, 32'(seed4),  ens);
        m16 = model_apply(16, m16, rs_n,   dvs, 32'(seed16), ens);
        #1;
        check("data8",  32'(data8),  m8);
        check("done8",  32'(done8),  32'(m8 == 32'(seed8)));
        check("data3",  32'(data3),  m3);
        check("done3",  32'(done3),  32'(m3 == 32'(seed3)));
        check("data4",  32'(data4),  m4);
        check("done4",  32'(done4),  32'(m4 == 32'(seed4)));
        check("data16", 32'(data16), m16);
        check("done16", 32'(done16), 32'(m16 == 32'(seed16)));
    endtask

    initial begin
        logic [7:0]  first5 [5];
        bit          seen [256];
        int          distinct;
        int          ff_seen;
        int          k_done;
        int          p3, p4, p16;
        logic [31:0] held;

        first5 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
        foreach (seen[i]) seen[i] = 1'b0;
        m8 = '0; m3 = '0; m4 = '0; m16 = '0;
        rst8_n = 1'b0; en8 = 1'b0; dv8 = 1'b0; seed8 = 8'h00;
        rs_n = 1'b0; ens = 1'b0; dvs = 1'b0;
        seed3 = '0; seed4 = '0; seed16 = '0;

        // Reset with seed 0
        tick(); tick();
        check("rst_data8", 32'(data8), 32'h00);
        check("rst_done8", 32'(done8), 32'd1);

        // Free-run from 0
        rst8_n = 1'b1; en8 = 1'b1;
        distinct = 0; ff_seen = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (k <= 5) check("first_steps", 32'(data8), 32'(first5[k-1]));
            if (!seen[data8]) distinct++;
            seen[data8] = 1'b1;
            if (data8 == 8'hFF) ff_seen++;
            if (k < 255) check("done_low_run", 32'(done8), 32'd0);
        end
        check("period_data", 32'(data8), 32'h00);
        check("period_done", 32'(done8), 32'd1);
        check("distinct", 32'(distinct), 32'd255);
        check("no_lockup_val", 32'(ff_seen), 32'd0);

        // Seed load while enabled: loads, does not step
        seed8 = 8'hA5; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        check("seed_data", 32'(data8), 32'hA5);
        check("seed_done", 32'(done8), 32'd1);
        k_done = 0;
        for (int k = 1; k <= 300 && k_done == 0; k++) begin
            tick();
            if (k == 1) check("seed_done_next", 32'(done8), 32'd0);
            if (done8) k_done = k;
        end
        check("seed_period", 32'(k_done), 32'd255);

        // Lock-up at all-ones
        seed8 = 8'hFF; dv8 = 1'b1; en8 = 1'b0;
        tick();
        dv8 = 1'b0; seed8 = 8'h00; en8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("lockup", 32'(data8), 32'hFF);
        end

        // Enable gating
        seed8 = 8'h3C; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        tick(); tick(); tick();
        en8 = 1'b0;
        held = m8;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("gate_hold", 32'(data8), held);
        end
        en8 = 1'b1;
        tick();
        check("gate_resume", 32'(data8), lfsr_next(8, held));

        // Reset overrides seed and enable
        seed8 = 8'h55; dv8 = 1'b1; rst8_n = 1'b0;
        tick();
        check("rst_override", 32'(data8), 32'h00);
        check("rst_override_done", 32'(done8), 32'd0);
        rst8_n = 1'b1; dv8 = 1'b0;

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            rst8_n = ($urandom_range(0, 19) != 0);
            dv8    = ($urandom_range(0, 9) == 0);
            en8    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) seed8 = 8'($urandom);
            tick();
        end
        rst8_n = 1'b0; en8 = 1'b0; dv8 = 1'b0;

        // Width sweep from reset
        check("sw_rst3",  32'(data3),  32'd0);
        check("sw_rst16", 32'(data16), 32'd0);
        rs_n = 1'b1; ens = 1'b1;
        tick();
        check("sw_first3",  32'(data3),  32'd1);
        check("sw_first4",  32'(data4),  32'd1);
        check("sw_first16", 32'(data16), 32'd1);
        p3 = 0; p4 = 0; p16 = 0;
        for (int k = 2; k <= 65540 && p16 == 0; k++) begin
            tick();
            if (done3  && p3  == 0) p3  = k;
            if (done4  && p4  == 0) p4  = k;
            if (done16 && p16 == 0) p16 = k;
        end
        check("period3",  32'(p3),  32'd7);
        check("period4",  32'(p4),  32'd15);
        check("period16", 32'(p16), 32'd65535);

        // Mid-sequence reset
        tick(); tick(); tick();
        rs_n = 1'b0;
        tick();
        check("mid_rst3",  32'(data3),  32'd0);
        check("mid_rst4",  32'(data4),  32'd0);
        check("mid_rst16", 32'(data16), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
